lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 32 +++
 rtl/lsu.sv | 156 +++++++++++++++
 tb/tb_lsu.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Request, response and byte-lane memory signals shared by the CPU side and the LSU.
interface lsu_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned LANES = 4;

    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [2:0]         req_funct3;
    logic [XLEN-1:0]    req_addr;
    logic [XLEN-1:0]    req_wdata;
    logic               resp_valid;
    logic               resp_ready;
    logic [XLEN-1:0]    resp_rdata;
    logic               resp_error;
    logic [XLEN-1:0]    mem_addr;
    logic [LANES-1:0]   mem_we;
    logic [XLEN-1:0]    mem_wr_data;
    logic [XLEN-1:0]    mem_rd_data;

    // LSU side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_we, mem_wr_data
    );

    // CPU / memory side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_we, mem_wr_data
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request per cycle into four byte-lane memories, with a
// one-entry hold buffer when the response consumer stalls.
module lsu (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Fields captured at fire time to format the response a cycle later
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic            r_err;

    // Response frozen while the consumer stalls
    logic [XLEN-1:0] hold_rdata;
    logic            hold_err;

    logic            ready;
    logic            fire;
    logic            req_illegal;
    logic            req_misaligned;
    logic            req_err;
    logic [LANES-1:0] store_mask;
    logic [XLEN-1:0] live_rdata;

    // Memory address follows the request address with no delay
    assign bus.mem_addr = bus.req_addr;

    // Request legality and alignment decode
    always_comb begin
        req_illegal    = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                         (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
        req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                         ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        req_err        = req_illegal || req_misaligned;
    end

    // Store lane mask and lane-replicated store data
    always_comb begin
        store_mask      = '0;
        bus.mem_wr_data = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                store_mask      = 4'(4'b0001 << bus.req_addr[1:0]);
                bus.mem_wr_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                store_mask      = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                bus.mem_wr_data = {2{bus.req_wdata[15:0]}};
            end
            2'b10: store_mask = 4'b1111;
            default: store_mask = '0;
        endcase
    end

    // Load formatting from the live lane read data at the registered offset
    always_comb begin
        logic [XLEN-1:0] shifted;
        logic [7:0]      byte_sel;
        logic [15:0]     half_sel;
        shifted    = bus.mem_rd_data >> {r_off, 3'b000};
        byte_sel   = 8'(shifted);
        half_sel   = r_off[1] ? bus.mem_rd_data[31:16] : bus.mem_rd_data[15:0];
        live_rdata = '0;
        if (!r_we && !r_err) begin
            case (r_funct3)
                3'b000:  live_rdata = {{24{byte_sel[7]}}, byte_sel};
                3'b100:  live_rdata = {24'd0, byte_sel};
                3'b001:  live_rdata = {{16{half_sel[15]}}, half_sel};
                3'b101:  live_rdata = {16'd0, half_sel};
                3'b010:  live_rdata = bus.mem_rd_data;
                default: live_rdata = '0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fire) state_nxt = RESP;
            RESP: begin
                if (bus.resp_ready) state_nxt = fire ? RESP : IDLE;
                else                state_nxt = HOLD;
            end
            HOLD: if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; writes are suppressed while rst is asserted
    always_comb begin
        ready          = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_error = 1'b0;
        case (state)
            IDLE: ready = 1'b1;
            RESP: begin
                ready          = bus.resp_ready;
                bus.resp_valid = 1'b1;
                bus.resp_rdata = live_rdata;
                bus.resp_error = r_err;
            end
            HOLD: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = hold_rdata;
                bus.resp_error = hold_err;
            end
            default: ready = 1'b0;
        endcase
        bus.req_ready = ready;
        fire          = bus.req_valid && ready && !rst;
        bus.mem_we    = (fire && bus.req_we && !req_err) ? store_mask : '0;
    end

    // Request field capture on fire, response capture on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_funct3   <= '0;
            r_off      <= '0;
            r_err      <= 1'b0;
            hold_rdata <= '0;
            hold_err   <= 1'b0;
        end else begin
            if (fire) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_off    <= bus.req_addr[1:0];
                r_err    <= req_err;
            end
            if (state == RESP && !bus.resp_ready) begin
                hold_rdata <= live_rdata;
                hold_err   <= r_err;
            end
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a four-lane byte memory model.
module tb_lsu;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    lsu_if bus ();

    lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four byte-lane memories with one-cycle read latency
    logic [7:0] lane [4][4096];
    initial begin
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4096; j++)
                lane[k][j] = 8'h00;
        bus.mem_rd_data = '0;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (bus.mem_we[k]) lane[k][bus.mem_addr[13:2]] <= bus.mem_wr_data[8*k +: 8];
        bus.mem_rd_data <= {lane[3][bus.mem_addr[13:2]], lane[2][bus.mem_addr[13:2]],
                            lane[1][bus.mem_addr[13:2]], lane[0][bus.mem_addr[13:2]]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single request with resp_ready=1, checks lane strobes then the response
    task automatic op(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ewe, input logic [31:0] ewd,
                      input logic [31:0] erd, input logic eerr);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.resp_ready = 1'b1;
        #1;
        check({tag, " mem_we"}, 32'(bus.mem_we), 32'(ewe));
        check({tag, " mem_addr"}, bus.mem_addr, a);
        if (ewe != 4'b0000) check({tag, " mem_wr_data"}, bus.mem_wr_data, ewd);
        @(posedge clk);
        #1;
        check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, " resp_rdata"}, bus.resp_rdata, erd);
        check({tag, " resp_error"}, 32'(bus.resp_error), 32'(eerr));
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    logic [31:0] b2b_addr [4];
    logic [2:0]  b2b_f3   [4];
    logic [31:0] b2b_exp  [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        rst = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst resp_error", 32'(bus.resp_error), 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst mem_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle req_ready", 32'(bus.req_ready), 32'd1);

        // Word store / load
        op("SW 100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
        op("LW 100", 1'b0, 3'b010, 32'h100, 32'h0, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);

        // Sub-word loads with sign/zero extension
        op("SW 104", 1'b1, 3'b010, 32'h104, 32'h000080F0, 4'b1111, 32'h000080F0, 32'h0, 1'b0);
        op("LB 104",  1'b0, 3'b000, 32'h104, 32'h0, 4'b0000, 32'h0, 32'hFFFFFFF0, 1'b0);
        op("LBU 105", 1'b0, 3'b100, 32'h105, 32'h0, 4'b0000, 32'h0, 32'h00000080, 1'b0);
        op("LH 104",  1'b0, 3'b001, 32'h104, 32'h0, 4'b0000, 32'h0, 32'hFFFF80F0, 1'b0);
        op("LHU 106", 1'b0, 3'b101, 32'h106, 32'h0, 4'b0000, 32'h0, 32'h00000000, 1'b0);

        // Sub-word stores and lane replication
        op("SB 10B", 1'b1, 3'b000, 32'h10B, 32'h000000AA, 4'b1000, 32'hAAAAAAAA, 32'h0, 1'b0);
        op("SH 10A", 1'b1, 3'b001, 32'h10A, 32'h00001234, 4'b1100, 32'h12341234, 32'h0, 1'b0);
        op("LW 108", 1'b0, 3'b010, 32'h108, 32'h0, 4'b0000, 32'h0, 32'h12340000, 1'b0);

        // Misaligned and illegal requests
        op("LW 102",  1'b0, 3'b010, 32'h102, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
        op("SH 101",  1'b1, 3'b001, 32'h101, 32'hFFFF, 4'b0000, 32'h0, 32'h0, 1'b1);
        op("L f3=011", 1'b0, 3'b011, 32'h100, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
        op("S f3=100", 1'b1, 3'b100, 32'h100, 32'h55, 4'b0000, 32'h0, 32'h0, 1'b1);
        op("LW 100 again", 1'b0, 3'b010, 32'h100, 32'h0, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);

        // Consumer stall: response held while the address moves on
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h100;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1;
        check("stall resp rdata", bus.resp_rdata, 32'hDEADBEEF);
        check("stall resp req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h104;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d valid", i), 32'(bus.resp_valid), 32'd1);
            check($sformatf("hold%0d rdata", i), bus.resp_rdata, 32'hDEADBEEF);
            check($sformatf("hold%0d req_ready", i), 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_addr  = bus.req_addr + 32'd4;
            #1;
            check($sformatf("hold%0d mem_we", i), 32'(bus.mem_we), 32'd0);
            bus.req_valid = 1'b0;
            bus.req_we    = 1'b0;
        end
        bus.resp_ready = 1'b1;
        #1;
        check("release rdata", bus.resp_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        check("release valid", 32'(bus.resp_valid), 32'd0);

        // Back-to-back loads, one response per cycle
        b2b_addr = '{32'h100, 32'h104, 32'h103, 32'h102};
        b2b_f3   = '{3'b010, 3'b010, 3'b100, 3'b001};
        b2b_exp  = '{32'hDEADBEEF, 32'h000080F0, 32'h000000DE, 32'hFFFFDEAD};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b0;
            bus.req_funct3 = b2b_f3[i];
            bus.req_addr   = b2b_addr[i];
            bus.resp_ready = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d valid", i), 32'(bus.resp_valid), 32'd1);
            check($sformatf("b2b%0d rdata", i), bus.resp_rdata, b2b_exp[i]);
        end

        // Reset mid-stream with a store presented: nothing written, response dropped
        @(negedge clk);
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h200;
        bus.req_wdata  = 32'h11111111;
        rst = 1'b1;
        #1;
        check("mid rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("mid rst mem_we", 32'(bus.mem_we), 32'd0);
        check("mid rst resp_rdata", bus.resp_rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h200;
        @(posedge clk);
        #1;
        check("post rst first fire valid", 32'(bus.resp_valid), 32'd1);
        check("post rst LW 200", bus.resp_rdata, 32'h00000000);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("final idle valid", 32'(bus.resp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
